// File: rtl/array_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : array_check_arbiter
// Description : Round-robin scheduler sharing one array-sort-check engine
//               among N_REQ requesters, with an ARM/RUN watchdog.
// Revision    : 1.0
// ============================================================================
module array_check_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_base,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        resp_valid,
    output logic                    resp_sorted,
    output logic                    resp_timeout,
    output logic                    busy,
    output logic                    eng_go,
    output logic [ADDR_W-1:0]       eng_base,
    output logic [LEN_W-1:0]        eng_len,
    input  logic                    eng_done,
    input  logic                    eng_sorted
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = (TIMEOUT > 0) ? c_cnt_w'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [c_idx_w-1:0]  r_last_q,    w_last_d;
    logic [c_idx_w-1:0]  r_winner_q,  w_winner_d;
    logic [ADDR_W-1:0]   r_base_q,    w_base_d;
    logic [LEN_W-1:0]    r_len_q,     w_len_d;
    logic [c_cnt_w-1:0]  r_cnt_q,     w_cnt_d;
    logic                r_sorted_q,  w_sorted_d;
    logic                r_timeout_q, w_timeout_d;

    logic [c_idx_w-1:0]  w_scan_idx;
    logic [c_idx_w-1:0]  w_pick;
    logic                w_found;
    logic [ADDR_W-1:0]   w_pick_base;
    logic [LEN_W-1:0]    w_pick_len;
    logic [c_cnt_w-1:0]  w_cnt_inc;
    logic                w_wdog;
    logic [N_REQ-1:0]    w_onehot;

    // Scan starts just after the last winner so a persistent requester goes to the back.
    always_comb begin
        w_scan_idx  = '0;
        w_pick      = r_last_q;
        w_found     = 1'b0;
        w_pick_base = '0;
        w_pick_len  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_scan_idx = c_idx_w'((int'(r_last_q) + i) % N_REQ);
            if (!w_found && req[w_scan_idx]) begin
                w_found = 1'b1;
                w_pick  = w_scan_idx;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == c_idx_w'(i)) begin
                w_pick_base = req_base[i*ADDR_W +: ADDR_W];
                w_pick_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_cnt_inc = (r_cnt_q == '1) ? r_cnt_q : r_cnt_q + c_cnt_w'(1);
    assign w_wdog    = (TIMEOUT > 0) && (r_cnt_q >= c_tmo_last);

    always_comb begin
        w_state_d   = r_state_q;
        w_last_d    = r_last_q;
        w_winner_d  = r_winner_q;
        w_base_d    = r_base_q;
        w_len_d     = r_len_q;
        w_cnt_d     = r_cnt_q;
        w_sorted_d  = r_sorted_q;
        w_timeout_d = r_timeout_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_found) begin
                    w_winner_d = w_pick;
                    w_last_d   = w_pick;
                    w_base_d   = w_pick_base;
                    w_len_d    = w_pick_len;
                    w_state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_d   = '0;
                w_state_d = ST_ARM;
            end
            // A done still high from the previous job must fall before the result counts.
            ST_ARM: begin
                w_cnt_d = w_cnt_inc;
                if (!eng_done) begin
                    w_state_d = ST_RUN;
                end else if (w_wdog) begin
                    w_sorted_d  = 1'b0;
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_RESP;
                end
            end
            ST_RUN: begin
                w_cnt_d = w_cnt_inc;
                if (eng_done) begin
                    w_sorted_d  = eng_sorted;
                    w_timeout_d = 1'b0;
                    w_state_d   = ST_RESP;
                end else if (w_wdog) begin
                    w_sorted_d  = 1'b0;
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_RESP;
                end
            end
            ST_RESP:  w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state_q   <= ST_IDLE;
            r_last_q    <= c_idx_w'(N_REQ - 1);
            r_winner_q  <= '0;
            r_base_q    <= '0;
            r_len_q     <= '0;
            r_cnt_q     <= '0;
            r_sorted_q  <= 1'b0;
            r_timeout_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_last_q    <= w_last_d;
            r_winner_q  <= w_winner_d;
            r_base_q    <= w_base_d;
            r_len_q     <= w_len_d;
            r_cnt_q     <= w_cnt_d;
            r_sorted_q  <= w_sorted_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    assign w_onehot     = {{(N_REQ-1){1'b0}}, 1'b1} << r_winner_q;
    assign busy         = (r_state_q != ST_IDLE);
    assign grant        = busy ? w_onehot : '0;
    assign eng_go       = (r_state_q == ST_ISSUE);
    assign resp_valid   = (r_state_q == ST_RESP) ? w_onehot : '0;
    assign resp_sorted  = (r_state_q == ST_RESP) && r_sorted_q;
    assign resp_timeout = (r_state_q == ST_RESP) && r_timeout_q;
    assign eng_base     = r_base_q;
    assign eng_len      = r_len_q;

endmodule
`default_nettype wire

// File: tb/tb_array_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_check_arbiter
// Description : Directed scoreboard bench for array_check_arbiter with a
//               behavioural engine model.
// Revision    : 1.0
// ============================================================================
module tb_array_check_arbiter;

    localparam int N = 4;
    localparam int A = 32;
    localparam int L = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*A-1:0] req_base;
    logic [N*L-1:0] req_len;
    logic [N-1:0]   grant;
    logic [N-1:0]   resp_valid;
    logic           resp_sorted;
    logic           resp_timeout;
    logic           busy;
    logic           eng_go;
    logic [A-1:0]   eng_base;
    logic [L-1:0]   eng_len;
    logic           eng_done;
    logic           eng_sorted;

    int n_checks = 0;
    int n_errors = 0;

    array_check_arbiter #(.N_REQ(N), .ADDR_W(A), .LEN_W(L), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .req(req), .req_base(req_base), .req_len(req_len),
        .grant(grant), .resp_valid(resp_valid), .resp_sorted(resp_sorted),
        .resp_timeout(resp_timeout), .busy(busy), .eng_go(eng_go), .eng_base(eng_base),
        .eng_len(eng_len), .eng_done(eng_done), .eng_sorted(eng_sorted)
    );

    always #5 clock = ~clock;

    // Engine model: e_cnt counts cycles since go; done stays high for drop_at
    // cycles, low for low_len cycles, then high; sorted is only valid on the rise.
    int e_cnt   = 0;
    bit stuck   = 1'b0;
    int drop_at = 0;
    int low_len = 2;
    bit sorted_val = 1'b1;

    always @(posedge clock) begin
        if (eng_go) e_cnt <= 1;
        else if (e_cnt != 0) e_cnt <= e_cnt + 1;
    end
    assign eng_done   = stuck ? 1'b1 : !(e_cnt > drop_at && e_cnt <= drop_at + low_len);
    assign eng_sorted = (e_cnt == drop_at + low_len + 1) ? sorted_val : !sorted_val;

    typedef struct {
        int          idx;
        logic [31:0] base;
        logic [31:0] len;
        bit          sorted;
        bit          tmo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] f_base[N];
    logic [31:0] f_len[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_field(input int i, input logic [31:0] b, input logic [31:0] l);
        f_base[i] = b;
        f_len[i]  = l;
        req_base[i*A +: A] = b;
        req_len[i*L +: L]  = l;
    endtask

    task automatic push_exp(input int idx, input bit s, input bit t, input int lat);
        exp_t e;
        e.idx = idx; e.base = f_base[idx]; e.len = f_len[idx];
        e.sorted = s; e.tmo = t; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clock);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_go", eng_go, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_base", eng_base, 0);
        chk("rst_len", eng_len, 0);
        reset = 1'b1;
    endtask

    // Waits for the next job, checks it against the scoreboard head, and
    // optionally drops requests the cycle after resp_valid.
    task automatic serve_one(input logic [N-1:0] drop_mask, output int go_wait);
        exp_t e;
        int   n;
        bit   got;
        got = 1'b0;
        go_wait = 0;
        while (go_wait < 20 && !got) begin
            @(negedge clock);
            go_wait++;
            got = eng_go;
        end
        chk("go_seen", got, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (!got || sb.size() == 0) return;
        e = sb.pop_front();
        chk("grant", grant, 64'(4'b0001 << e.idx));
        chk("eng_base", eng_base, e.base);
        chk("eng_len", eng_len, e.len);
        chk("busy", busy, 1);
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clock);
            n++;
            if (n == 1) chk("go_one_cycle", eng_go, 0);
            got = (resp_valid != 0);
        end
        chk("resp_seen", got, 1);
        chk("latency", n, e.lat);
        chk("resp_valid", resp_valid, 64'(4'b0001 << e.idx));
        chk("resp_sorted", resp_sorted, e.sorted);
        chk("resp_timeout", resp_timeout, e.tmo);
        chk("grant_held", grant, 64'(4'b0001 << e.idx));
        chk("base_stable", eng_base, e.base);
        req = req & ~drop_mask;
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
        chk("idle_resp", resp_valid, 0);
    endtask

    initial begin
        int gw;
        reset = 1'b0;
        req = '0;
        req_base = '0;
        req_len = '0;
        for (int i = 0; i < N; i++) set_field(i, 32'h0, 32'h0);

        // Single requester, sorted result.
        do_reset();
        set_field(1, 32'h100, 32'd5);
        sorted_val = 1'b1;
        req = 4'b0010;
        push_exp(1, 1'b1, 1'b0, 4);
        serve_one(4'b0010, gw);
        chk("t1_go_latency", gw, 1);

        // All four requesting from reset: served 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) set_field(i, 32'h1000 + 32'(i) * 32'h10, 32'(i) + 32'd3);
        req = 4'b1111;
        for (int i = 0; i < N; i++) push_exp(i, (i % 2) == 1, 1'b0, 4);
        for (int i = 0; i < N; i++) begin
            sorted_val = (i % 2) == 1;
            serve_one(4'(1 << i), gw);
        end

        // Two persistent requesters alternate.
        sorted_val = 1'b1;
        req = 4'b0101;
        push_exp(0, 1'b1, 1'b0, 4);
        push_exp(2, 1'b1, 1'b0, 4);
        push_exp(0, 1'b1, 1'b0, 4);
        push_exp(2, 1'b1, 1'b0, 4);
        serve_one(4'b0000, gw);
        serve_one(4'b0000, gw);
        serve_one(4'b0000, gw);
        serve_one(4'b0101, gw);

        // Stale done at go: result only after done falls and rises again.
        drop_at = 1;
        low_len = 6;
        sorted_val = 1'b0;
        req = 4'b0100;
        push_exp(2, 1'b0, 1'b0, 9);
        serve_one(4'b0100, gw);
        drop_at = 0;
        low_len = 2;

        // Engine never drops done: watchdog fires, then the other requester runs normally.
        stuck = 1'b1;
        sorted_val = 1'b1;
        req = 4'b1001;
        push_exp(3, 1'b0, 1'b1, 17);
        push_exp(0, 1'b1, 1'b0, 4);
        serve_one(4'b1000, gw);
        stuck = 1'b0;
        serve_one(4'b0001, gw);

        // Reset during RUN aborts silently and restarts arbitration at requester 0.
        low_len = 10;
        req = 4'b0010;
        gw = 0;
        while (gw < 20 && !eng_go) begin
            @(negedge clock);
            gw++;
        end
        chk("t6_go_seen", eng_go, 1);
        repeat (3) @(negedge clock);
        chk("t6_busy_before", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("t6_grant", grant, 0);
        chk("t6_busy", busy, 0);
        chk("t6_resp", resp_valid, 0);
        chk("t6_base", eng_base, 0);
        @(negedge clock);
        chk("t6_resp_hold", resp_valid, 0);
        low_len = 2;
        reset = 1'b1;
        req = 4'b1111;
        push_exp(0, 1'b1, 1'b0, 4);
        serve_one(4'b1111, gw);
        chk("t6_go_latency", gw, 1);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
